// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: instruction register, Moore FSM
// (fetch/decode/exec/mem/wb/halt) with memory handshakes and a saturating retire counter.
module multicycle_control #(
  parameter int INSTR_WIDTH  = 16,
  parameter int OP_WIDTH     = 4,
  parameter int ALU_OP_WIDTH = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  input  logic                    imem_ready,
  input  logic [INSTR_WIDTH-1:0]  instr,
  output logic [INSTR_WIDTH-1:0]  ir,
  output logic                    dmem_req,
  output logic                    dmem_we,
  input  logic                    dmem_ready,
  input  logic                    alu_zero,
  output logic                    alu_en,
  output logic                    alu_use_imm,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    reg_write_en,
  output logic                    pc_inc,
  output logic                    pc_branch,
  output logic                    pc_jump,
  output logic                    halted,
  output logic                    illegal_op,
  output logic [COUNT_WIDTH-1:0]  retired,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADDI = {2'b01, {(OP_WIDTH-2){1'b0}}};
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_ADDI + OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_ADDI + OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_ADDI + OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = {1'b1, {(OP_WIDTH-1){1'b0}}};
  localparam logic [OP_WIDTH-1:0] OP_HALT = {OP_WIDTH{1'b1}};

  state_t                   state_r;
  logic [INSTR_WIDTH-1:0]   ir_r;
  logic [COUNT_WIDTH-1:0]   retired_r;
  logic [OP_WIDTH-1:0]      op_s;
  logic                     is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_jmp_s;
  logic                     is_halt_s, is_illegal_s, retire_s;

  assign op_s         = ir_r[INSTR_WIDTH-1 -: OP_WIDTH];
  assign is_r_s       = (op_s[OP_WIDTH-1 -: 2] == 2'b00);
  assign is_addi_s    = (op_s == OP_ADDI);
  assign is_lw_s      = (op_s == OP_LW);
  assign is_sw_s      = (op_s == OP_SW);
  assign is_beq_s     = (op_s == OP_BEQ);
  assign is_jmp_s     = (op_s == OP_JMP);
  assign is_halt_s    = (op_s == OP_HALT);
  assign is_illegal_s = ~(is_r_s | is_addi_s | is_lw_s | is_sw_s | is_beq_s | is_jmp_s | is_halt_s);

  // An instruction completes at its last active cycle; HALT and illegal opcodes never count.
  assign retire_s = ~reset & (((state_r == S_EXEC) & (is_beq_s | is_jmp_s)) |
                              ((state_r == S_MEM) & is_sw_s & dmem_ready) |
                              (state_r == S_WB));

  assign ir      = ir_r;
  assign retired = retired_r;
  assign state   = state_r;

  // Sequencer state, instruction register and saturating retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      ir_r      <= {INSTR_WIDTH{1'b0}};
      retired_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      if (retire_s && (retired_r != {COUNT_WIDTH{1'b1}})) begin
        retired_r <= retired_r + COUNT_WIDTH'(1);
      end
      case (state_r)
        S_FETCH: begin
          if (imem_ready) begin
            ir_r    <= instr;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt_s)         state_r <= S_HALT;
          else if (is_illegal_s) state_r <= S_FETCH;
          else                   state_r <= S_EXEC;
        end
        S_EXEC: begin
          if (is_r_s || is_addi_s)    state_r <= S_WB;
          else if (is_lw_s || is_sw_s) state_r <= S_MEM;
          else                         state_r <= S_FETCH;
        end
        S_MEM: begin
          if (dmem_ready) state_r <= is_lw_s ? S_WB : S_FETCH;
        end
        S_WB:    state_r <= S_FETCH;
        S_HALT:  state_r <= S_HALT;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Moore strobe decode; reset forces every strobe low in the same cycle.
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_en       = 1'b0;
    alu_use_imm  = 1'b0;
    alu_op       = {ALU_OP_WIDTH{1'b0}};
    reg_write_en = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    if (reset) begin
      imem_req = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          imem_req = 1'b1;
          pc_inc   = imem_ready;
        end
        S_DECODE: illegal_op = is_illegal_s;
        S_EXEC: begin
          alu_en      = 1'b1;
          alu_op      = op_s[OP_WIDTH-3 -: ALU_OP_WIDTH];
          alu_use_imm = is_addi_s | is_lw_s | is_sw_s;
          pc_branch   = is_beq_s & alu_zero;
          pc_jump     = is_jmp_s;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw_s;
        end
        S_WB:    reg_write_en = 1'b1;
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
  logic [15:0] instr = 16'h0000;

  logic        imem_req, dmem_req, dmem_we, alu_en, alu_use_imm, reg_write_en;
  logic        pc_inc, pc_branch, pc_jump, halted, illegal_op;
  logic [1:0]  alu_op;
  logic [15:0] ir, retired;
  logic [2:0]  state;

  logic        imem_req2, dmem_req2, dmem_we2, alu_en2, alu_use_imm2, reg_write_en2;
  logic        pc_inc2, pc_branch2, pc_jump2, halted2, illegal_op2;
  logic [1:0]  alu_op2, retired2;
  logic [15:0] ir2;
  logic [2:0]  state2;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
    .ir(ir), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .alu_en(alu_en), .alu_use_imm(alu_use_imm), .alu_op(alu_op),
    .reg_write_en(reg_write_en), .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .halted(halted), .illegal_op(illegal_op), .retired(retired), .state(state)
  );

  multicycle_control #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_ready(imem_ready), .instr(instr),
    .ir(ir2), .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .alu_en(alu_en2), .alu_use_imm(alu_use_imm2), .alu_op(alu_op2),
    .reg_write_en(reg_write_en2), .pc_inc(pc_inc2), .pc_branch(pc_branch2), .pc_jump(pc_jump2),
    .halted(halted2), .illegal_op(illegal_op2), .retired(retired2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_retired();
    chk("retired", 32'(retired), (exp_ret > 65535) ? 32'd65535 : 32'(exp_ret));
    chk("retired_sat2", 32'(retired2), (exp_ret > 3) ? 32'd3 : 32'(exp_ret));
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_req_hold", 32'(imem_req), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_imem_req", 32'(imem_req), 32'd1);
    exp_ret = 0;
  endtask

  // Drive one instruction through the FSM, checking every cycle against the opcode's class.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                           input bit z, input int abort_at);
    logic [3:0] op = ins[15:12];
    bit is_r   = (op[3:2] == 2'b00);
    bit is_add = (op == 4'h4);
    bit is_lw  = (op == 4'h5);
    bit is_sw  = (op == 4'h6);
    bit is_beq = (op == 4'h7);
    bit is_jmp = (op == 4'h8);
    bit is_hlt = (op == 4'hF);
    bit is_ill = !(is_r || is_add || is_lw || is_sw || is_beq || is_jmp || is_hlt);
    for (int k = 0; k <= iw; k++) begin
      @(negedge clk);
      imem_ready = (k == iw);
      instr = (k == iw) ? ins : 16'($urandom);
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (k == 0) chk_retired();
      chk("fetch_state", 32'(state), 32'd0);
      chk("fetch_imem_req", 32'(imem_req), 32'd1);
      chk("fetch_pc_inc", 32'(pc_inc), 32'(k == iw));
      chk("fetch_dmem_req", 32'(dmem_req), 32'd0);
    end
    @(negedge clk);
    imem_ready = 1'($urandom_range(0, 1));
    dmem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("dec_state", 32'(state), 32'd1);
    chk("dec_ir", 32'(ir), 32'(ins));
    chk("dec_illegal", 32'(illegal_op), 32'(is_ill));
    chk("dec_imem_req", 32'(imem_req), 32'd0);
    chk("dec_alu_en", 32'(alu_en), 32'd0);
    chk("dec_halted", 32'(halted), 32'd0);
    if (is_ill || is_hlt) return;
    @(negedge clk); alu_zero = z; #1;
    chk("exec_state", 32'(state), 32'd2);
    chk("exec_alu_en", 32'(alu_en), 32'd1);
    chk("exec_alu_op", 32'(alu_op), 32'(ins[13:12]));
    chk("exec_use_imm", 32'(alu_use_imm), 32'(is_add || is_lw || is_sw));
    chk("exec_pc_branch", 32'(pc_branch), 32'(is_beq && z));
    chk("exec_pc_jump", 32'(pc_jump), 32'(is_jmp));
    chk("exec_reg_we", 32'(reg_write_en), 32'd0);
    chk("exec_pc_inc", 32'(pc_inc), 32'd0);
    if (is_beq || is_jmp) begin
      exp_ret++;
      return;
    end
    if (is_lw || is_sw) begin
      for (int k = 0; k <= dw; k++) begin
        @(negedge clk);
        dmem_ready = (k == dw);
        imem_ready = 1'($urandom_range(0, 1));
        #1;
        if (k == abort_at) begin
          reset = 1'b1; #1;
          chk("abort_dmem_req", 32'(dmem_req), 32'd0);
          chk("abort_imem_req", 32'(imem_req), 32'd0);
          @(negedge clk); reset = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b0; #1;
          chk("abort_state", 32'(state), 32'd0);
          chk("abort_retired", 32'(retired), 32'd0);
          exp_ret = 0;
          return;
        end
        chk("mem_state", 32'(state), 32'd3);
        chk("mem_dmem_req", 32'(dmem_req), 32'd1);
        chk("mem_dmem_we", 32'(dmem_we), 32'(is_sw));
        chk("mem_alu_en", 32'(alu_en), 32'd0);
        chk("mem_reg_we", 32'(reg_write_en), 32'd0);
      end
      if (is_sw) begin
        exp_ret++;
        return;
      end
    end
    @(negedge clk); dmem_ready = 1'($urandom_range(0, 1)); #1;
    chk("wb_state", 32'(state), 32'd4);
    chk("wb_reg_we", 32'(reg_write_en), 32'd1);
    chk("wb_alu_en", 32'(alu_en), 32'd0);
    chk("wb_dmem_req", 32'(dmem_req), 32'd0);
    exp_ret++;
  endtask

  function automatic logic [15:0] rand_ins(input int cls);
    logic [11:0] low = 12'($urandom);
    case (cls)
      0:       rand_ins = {2'b00, 14'($urandom)};
      1:       rand_ins = {4'h4, low};
      2:       rand_ins = {4'h5, low};
      3:       rand_ins = {4'h6, low};
      4:       rand_ins = {4'h7, low};
      5:       rand_ins = {4'h8, low};
      default: rand_ins = {4'($urandom_range(9, 14)), low};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    run_instr(16'h0123, 0, 0, 1'b0, -1);
    run_instr(rand_ins(2), 1, 3, 1'b0, -1);
    run_instr(rand_ins(3), 0, 3, 1'b0, -1);
    run_instr(rand_ins(4), 0, 0, 1'b1, -1);
    run_instr(rand_ins(4), 2, 0, 1'b0, -1);
    run_instr(rand_ins(5), 0, 0, 1'b0, -1);
    run_instr({4'h9, 12'($urandom)}, 0, 0, 1'b0, -1);

    do_reset();
    for (int i = 0; i < 5; i++) run_instr(rand_ins(1), 0, 0, 1'b0, -1);
    run_instr(16'h0123, 0, 0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      run_instr(rand_ins($urandom_range(0, 6)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    run_instr(rand_ins(2), 0, 3, 1'b0, 2);
    run_instr(rand_ins(0), 0, 0, 1'b0, -1);

    run_instr({4'hF, 12'($urandom)}, 1, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1)); #1;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_imem_req", 32'(imem_req), 32'd0);
      chk("halt_alu_en", 32'(alu_en), 32'd0);
      chk("halt_dmem_req", 32'(dmem_req), 32'd0);
    end
    chk_retired();
    do_reset();
    run_instr(16'h0123, 0, 0, 1'b0, -1);
    @(negedge clk); imem_ready = 1'b0; #1;
    chk_retired();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control sequencer for the little-computer core, replacing the purely combinational opcode decoder. It owns the instruction register and a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, with ready/request handshakes to instruction and data memory. It drives ALU, register-file, PC and memory enables, and keeps a retired-instruction counter.

Parameters:
INSTR_WIDTH, 16, instruction width; opcode is the top OP_WIDTH bits
OP_WIDTH, 4, opcode width (>=4)
ALU_OP_WIDTH, 2, ALU op field = opcode bits [OP_WIDTH-3 -: ALU_OP_WIDTH]
COUNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction valid on instr this cycle
instr  in  INSTR_WIDTH  fetched instruction
ir  out  INSTR_WIDTH  instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data write (SW), qualified by dmem_req
dmem_ready  in  1  data access complete
alu_zero  in  1  ALU result == 0 (BEQ compare)
alu_en  out  1  ALU result capture strobe
alu_use_imm  out  1  ALU B operand = immediate
alu_op  out  ALU_OP_WIDTH  ALU function
reg_write_en  out  1  register-file write strobe
pc_inc  out  1  PC += 1 strobe
pc_branch  out  1  PC += offset strobe
pc_jump  out  1  PC = target strobe
halted  out  1  sticky halt
illegal_op  out  1  one-cycle pulse on undefined opcode
retired  out  COUNT_WIDTH  retired-instruction count
state  out  3  FSM state (debug)

Behaviour:
- Opcode classes (top two opcode bits, low bits for OP_WIDTH=4): 00xx R-type ALU; 0100 ADDI; 0101 LW; 0110 SW; 0111 BEQ; 1000 JMP; 1111 HALT; all other 1xxx illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6/7 unreachable; if entered, go to FETCH.
- Reset: state=FETCH, ir=0, retired=0, halted=0; all strobes 0 while reset is high (imem_req = FETCH & ~reset).
- FETCH: imem_req=1; on imem_ready, ir<=instr, pc_inc=1 that cycle, go DECODE; else stay.
- DECODE: one cycle. HALT -> HALT. Illegal -> illegal_op=1, FETCH, not retired. Otherwise -> EXEC.
- EXEC: alu_en=1 one cycle. alu_op from ir. alu_use_imm=1 for ADDI/LW/SW, 0 for R-type/BEQ.
  - R-type/ADDI -> WB.
  - LW/SW -> MEM.
  - BEQ: pc_branch = alu_zero; retire; -> FETCH.
  - JMP: pc_jump=1; retire; -> FETCH.
- MEM: dmem_req=1, dmem_we = (SW). Hold both until dmem_ready. On dmem_ready: LW -> WB; SW -> retire, FETCH.
- WB: reg_write_en=1 for exactly one cycle; retire; -> FETCH.
- HALT: halted=1; all other strobes 0; leave only on reset. HALT is not counted as retired.
- retired increments by 1 on each retire event and saturates at all-ones.
- Moore outputs: all strobes decode from state and ir only. The exceptions are pc_inc (FETCH & imem_ready) and pc_branch (EXEC & BEQ & alu_zero).
- Reset asserted mid-access (FETCH or MEM waiting): request drops in the same cycle, FSM restarts at FETCH, and no partial retire is counted.
- imem_ready/dmem_ready outside their wait states are ignored.

Test Plan:
- Reset then R-type 0x0123 with imem_ready in the first cycle -> states 0,1,2,4,0. reg_write_en high one cycle in WB, alu_op=2'b00, alu_use_imm=0, retired=1.
- LW 0x5xxx with dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, alu_use_imm=1, then WB with reg_write_en, retired=1. Same for SW 0x6xxx: dmem_we=1, no WB.
- BEQ 0x7xxx: alu_zero=1 -> pc_branch pulse in EXEC. Rerun with alu_zero=0 -> no pulse. Both cases retire with no reg_write_en.
- HALT 0xFxxx -> halted=1 from the cycle after DECODE. Stays high for 20 cycles with imem_req=0. Reset clears it and imem_req returns.
- Opcode 0x9xxx -> illegal_op pulses one cycle in DECODE, FSM returns to FETCH, retired unchanged.
- COUNT_WIDTH=2 with 5 ADDIs -> retired saturates at 3. Reset asserted during a MEM wait -> dmem_req=0 in that cycle, next state FETCH, retired=0.
